// File: rtl/ctrl_seq_driver_if.sv
// Bundles the host request/result signals and the A/K1/K2 responder link
// of the control-sequence initiator.
interface ctrl_seq_driver_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start_i;
  logic [CNT_W-1:0] t1_i;
  logic [CNT_W-1:0] t2_i;
  logic [CNT_W-1:0] t3_i;
  logic             a_o;
  logic             k1_i;
  logic             k2_i;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic [1:0]       err_o;
  logic [CNT_W-1:0] lat_o;

  // Initiator view: the sequence driver itself.
  modport master (
    input  start_i, t1_i, t2_i, t3_i, k1_i, k2_i,
    output a_o, busy_o, done_o, pass_o, err_o, lat_o
  );

  // Environment view: host plus responder.
  modport slave (
    output start_i, t1_i, t2_i, t3_i, k1_i, k2_i,
    input  a_o, busy_o, done_o, pass_o, err_o, lat_o
  );
endinterface

// File: rtl/ctrl_seq_driver.sv
// Initiator for the A / K1,K2 control handshake: drives A through
// IDLE->START->STOP->CLEAR->IDLE, checks the responder and reports the
// result, error code and K2 latency.
module ctrl_seq_driver #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RESP_MAX = 16
) (
  input  logic               clk_i,
  input  logic               rst_n,
  ctrl_seq_driver_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_PH2  = 3'd2,
    S_PH3  = 3'd3,
    S_PH4  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [1:0]       ERR_NONE  = 2'b00;
  localparam logic [1:0]       ERR_TMO   = 2'b01;
  localparam logic [1:0]       ERR_K1    = 2'b10;
  localparam logic [1:0]       ERR_K2CLR = 2'b11;
  localparam logic [CNT_W-1:0] RESP_LIM  = CNT_W'(RESP_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic             seen_q, seen_d;
  logic             a_q, a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             abort;
  logic [1:0]       abort_err;
  logic             k2_seen;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath; outputs are registered from the next state so
  // that A and the status lines come straight from flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t1_d      = t1_q;
    t2_d      = t2_q;
    t3_d      = t3_q;
    seen_d    = seen_q;
    pass_d    = pass_q;
    err_d     = err_q;
    lat_d     = lat_q;
    abort     = 1'b0;
    abort_err = ERR_NONE;
    k2_seen   = seen_q | bus.k2_i;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          t1_d    = (bus.t1_i == '0) ? CNT_W'(1) : bus.t1_i;
          t2_d    = (bus.t2_i == '0) ? CNT_W'(1) : bus.t2_i;
          t3_d    = (bus.t3_i == '0) ? CNT_W'(1) : bus.t3_i;
          pass_d  = 1'b0;
          err_d   = ERR_NONE;
          lat_d   = '0;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = S_PH1;
        end
      end
      S_PH1: begin
        if (cnt_q == t1_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_PH2;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PH2: begin
        if (cnt_q == '0 && bus.k2_i) begin
          abort     = 1'b1;
          abort_err = ERR_K2CLR;
        end else if (cnt_q == t2_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_PH3;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PH3: begin
        if (bus.k2_i && !seen_q) begin
          seen_d = 1'b1;
          lat_d  = cnt_q;
        end
        if (k2_seen && cnt_q >= t3_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_PH4;
        end else if (!k2_seen && cnt_q == RESP_LIM) begin
          abort     = 1'b1;
          abort_err = ERR_TMO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PH4: begin
        cnt_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        seen_d  = 1'b0;
        pass_d  = 1'b0;
        err_d   = ERR_NONE;
        lat_d   = '0;
      end
    endcase

    // K1 outranks the phase-local checks, so it overrides their error code.
    if (state_q inside {S_PH1, S_PH2, S_PH3, S_PH4} && bus.k1_i) begin
      abort     = 1'b1;
      abort_err = ERR_K1;
    end

    if (abort) begin
      err_d   = abort_err;
      cnt_d   = '0;
      state_d = S_DONE;
    end

    if (state_d == S_DONE) pass_d = (err_d == ERR_NONE);

    a_d    = (state_d == S_PH1) || (state_d == S_PH3);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      t1_q   <= '0;
      t2_q   <= '0;
      t3_q   <= '0;
      seen_q <= 1'b0;
      a_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= ERR_NONE;
      lat_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      t3_q   <= t3_d;
      seen_q <= seen_d;
      a_q    <= a_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      lat_q  <= lat_d;
    end
  end

  assign bus.a_o    = a_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.pass_o = pass_q;
  assign bus.err_o  = err_q;
  assign bus.lat_o  = lat_q;

endmodule

// File: tb/tb_ctrl_seq_driver.sv
// Bench for ctrl_seq_driver: a behavioural responder plus a scoreboard of
// expected per-sequence results (A waveform, busy length, pass/err/lat).
module tb_ctrl_seq_driver;

  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic        pass;
    logic [1:0]  err;
    logic [7:0]  lat;
    int unsigned len;
    logic [31:0] apat;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_done = 0;
  int unsigned k2_mode = 0;   // 0 responder, 1 tied low, 2 tied high
  logic [1:0]  r_q;           // responder: 0 idle, 1 start, 2 stop, 3 clear
  exp_t sb[$];
  int unsigned rec_len = 0;
  logic [31:0] rec_pat = '0;

  ctrl_seq_driver_if #(.CNT_W(CNT_W)) bus ();

  ctrl_seq_driver #(.CNT_W(CNT_W), .RESP_MAX(16)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Responder model: registered K2, asserted in its CLEAR phase.
  always @(posedge clk_i) begin
    if (!rst_n || !bus.busy_o) r_q <= 2'd0;
    else case (r_q)
      2'd0: if (bus.a_o)  r_q <= 2'd1;
      2'd1: if (!bus.a_o) r_q <= 2'd2;
      2'd2: if (bus.a_o)  r_q <= 2'd3;
      default: if (!bus.a_o) r_q <= 2'd0;
    endcase
  end

  assign bus.k2_i = (k2_mode == 0) ? (r_q == 2'd3) : (k2_mode == 2);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: records A while busy, compares on done.
  always @(negedge clk_i) begin
    if (!bus.busy_o) begin
      rec_len = 0;
      rec_pat = '0;
    end else begin
      rec_pat = {rec_pat[30:0], bus.a_o};
      rec_len++;
      if (bus.done_o) begin
        n_done++;
        if (sb.size() == 0) begin
          check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("pass", {31'd0, bus.pass_o}, {31'd0, e.pass});
          check_eq("err", {30'd0, bus.err_o}, {30'd0, e.err});
          check_eq("lat", {24'd0, bus.lat_o}, {24'd0, e.lat});
          check_eq("busy_len", rec_len, e.len);
          check_eq("a_pattern", rec_pat, e.apat);
        end
      end
    end
  end

  task automatic run_seq(input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] t3,
                         input int unsigned k1_at, input bit poke, input exp_t e);
    bit got_done;
    got_done = 1'b0;
    sb.push_back(e);
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.t1_i = t1;
    bus.t2_i = t2;
    bus.t3_i = t3;
    @(posedge clk_i);
    #1 bus.start_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (i == 0) begin
        check_eq("busy_first", {31'd0, bus.busy_o}, 32'd1);
        check_eq("a_first", {31'd0, bus.a_o}, 32'd1);
      end
      if (bus.done_o) begin
        got_done = 1'b1;
        break;
      end
      bus.k1_i    = (i == k1_at);
      bus.start_i = poke && (i == 2);
      if (poke && i == 2) begin
        bus.t1_i = 8'd7;
        bus.t2_i = 8'd7;
        bus.t3_i = 8'd7;
      end
    end
    bus.k1_i    = 1'b0;
    bus.start_i = 1'b0;
    if (!got_done) check_eq("done_timeout", 32'd0, 32'd1);
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t nom;
    exp_t e;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.t1_i = '0;
    bus.t2_i = '0;
    bus.t3_i = '0;
    bus.k1_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_a", {31'd0, bus.a_o}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done_o}, 32'd0);
    check_eq("rst_pass", {31'd0, bus.pass_o}, 32'd0);
    check_eq("rst_err", {30'd0, bus.err_o}, 32'd0);
    check_eq("rst_lat", {24'd0, bus.lat_o}, 32'd0);
    rst_n = 1'b1;

    // Nominal: A = 11 000 11 0, done 9 cycles after start.
    nom = '{pass: 1'b1, err: 2'b00, lat: 8'd1, len: 9, apat: 32'b110001100};
    run_seq(8'd2, 8'd3, 8'd1, 99, 1'b0, nom);

    // Zero lengths behave as 1: A = 1 0 11 0.
    e = '{pass: 1'b1, err: 2'b00, lat: 8'd1, len: 6, apat: 32'b101100};
    run_seq(8'd0, 8'd0, 8'd0, 99, 1'b0, e);

    // T3 longer than the K2 latency: phase 3 lasts T3 cycles.
    e = '{pass: 1'b1, err: 2'b00, lat: 8'd1, len: 9, apat: 32'b100111100};
    run_seq(8'd1, 8'd2, 8'd4, 99, 1'b0, e);

    // Dead responder: phase 3 high for counter 0..16, then abort.
    k2_mode = 1;
    e = '{pass: 1'b0, err: 2'b01, lat: 8'd0, len: 20, apat: {12'd0, 1'b1, 1'b0, 17'h1FFFF, 1'b0}};
    run_seq(8'd1, 8'd1, 8'd1, 99, 1'b0, e);
    k2_mode = 0;

    // K1 raised during the first phase-2 cycle.
    e = '{pass: 1'b0, err: 2'b10, lat: 8'd0, len: 4, apat: 32'b1100};
    run_seq(8'd2, 8'd3, 8'd1, 2, 1'b0, e);

    // K2 stuck high: caught at the end of the first phase-2 cycle.
    k2_mode = 2;
    e = '{pass: 1'b0, err: 2'b11, lat: 8'd0, len: 4, apat: 32'b1100};
    run_seq(8'd2, 8'd3, 8'd1, 99, 1'b0, e);
    k2_mode = 0;

    // Start pulsed while busy is dropped.
    run_seq(8'd2, 8'd3, 8'd1, 99, 1'b1, nom);

    // Reset in the middle of phase 3.
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.t1_i = 8'd1;
    bus.t2_i = 8'd1;
    bus.t3_i = 8'd10;
    @(posedge clk_i);
    #1 bus.start_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check_eq("ph3_a_high", {31'd0, bus.a_o}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("mid_rst_a", {31'd0, bus.a_o}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check_eq("mid_rst_done", {31'd0, bus.done_o}, 32'd0);
    check_eq("mid_rst_pass", {31'd0, bus.pass_o}, 32'd0);
    check_eq("mid_rst_err", {30'd0, bus.err_o}, 32'd0);
    check_eq("mid_rst_lat", {24'd0, bus.lat_o}, 32'd0);
    rst_n = 1'b1;

    // Clean run after reset.
    run_seq(8'd2, 8'd3, 8'd1, 99, 1'b0, nom);

    repeat (3) @(negedge clk_i);
    check_eq("done_count", n_done, 32'd8);
    check_eq("sb_left", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
